// File: rtl/n64a_testpattern_gen.sv
// n64a_testpattern_gen
//
// Test-image generator for the N64 video path. It follows the incoming sync
// stream and keeps horizontal and vertical pixel counters. Inside a window
// that depends on the video mode, it replaces the colour data with one of
// four patterns. The sync bits pass through with the same one-strobe
// latency as the pixel data.
//
// Ports:
//   VCLK       video clock
//   nRST       asynchronous active-low reset
//   nDSYNC     pixel strobe, active-low; all state advances only on a strobe
//   vmode      0 = NTSC vertical window, 1 = PAL vertical window (sampled live)
//   pat_sel    0 fine checker, 1 coarse checker, 2 colour bars, 3 ramp
//   Sync_in    {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   vdata_out  {sync[3:0], R, G, B}, registered on the strobe
//   in_window  high when the pixel on vdata_out lies inside the active window
module n64a_testpattern_gen #(
  parameter int         COLOR_W     = 7,
  parameter logic [9:0] HSTART      = 10'd100,
  parameter logic [9:0] HSTOP       = 10'd740,
  parameter logic [8:0] VSTART_NTSC = 9'd18,
  parameter logic [8:0] VSTOP_NTSC  = 9'd258,
  parameter logic [8:0] VSTART_PAL  = 9'd23,
  parameter logic [8:0] VSTOP_PAL   = 9'd311,
  parameter int         CB_SHIFT    = 3,
  parameter int         BAR_W       = 80,
  parameter int         RAMP_SHIFT  = 2
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   nDSYNC,
  input  logic                   vmode,
  input  logic [1:0]             pat_sel,
  input  logic [3:0]             Sync_in,
  output logic [3*COLOR_W+3:0]   vdata_out,
  output logic                   in_window
);

  localparam int                 SYNC_LSB = 3 * COLOR_W;
  localparam int                 BCW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int                 LVL_MAX  = (1 << COLOR_W) - 1;
  localparam logic [BCW-1:0]     BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] LVL_ONES = '1;

  logic [9:0]           hcnt_q, hcnt_d;
  logic [8:0]           vcnt_q, vcnt_d;
  logic [1:0]           pat_q, pat_d;
  logic                 phase_q, phase_d;
  logic [BCW-1:0]       bar_cnt_q, bar_cnt_d;
  logic [2:0]           bar_idx_q, bar_idx_d;
  logic [3*COLOR_W+3:0] vdata_q, vdata_d;
  logic                 win_q, win_d;

  logic                 hs_pos, vs_pos;
  logic [8:0]           vstart, vstop;
  logic [9:0]           hx, vy, ramp_full;
  logic                 cb_bit;
  logic [COLOR_W-1:0]   r_d, g_d, b_d, ramp_lvl;

  always_comb begin
    // Edges are taken against the sync bits already sitting on vdata_out.
    hs_pos = ~vdata_q[SYNC_LSB+1] & Sync_in[1];
    vs_pos = ~vdata_q[SYNC_LSB+3] & Sync_in[3];

    hcnt_d = hs_pos ? 10'd0 : ((hcnt_q == 10'h3FF) ? hcnt_q : hcnt_q + 10'd1);

    // The vsync clear takes priority over the line increment.
    vcnt_d = vcnt_q;
    if (vs_pos) begin
      vcnt_d = 9'd0;
    end else if (hs_pos && (vcnt_q != 9'h1FF)) begin
      vcnt_d = vcnt_q + 9'd1;
    end

    pat_d  = vs_pos ? pat_sel : pat_q;

    vstart = vmode ? VSTART_PAL : VSTART_NTSC;
    vstop  = vmode ? VSTOP_PAL  : VSTOP_NTSC;

    // The window and pattern are evaluated at the position of the pixel
    // arriving on this strobe, i.e. the updated counter values.
    win_d  = (vcnt_d > vstart) && (vcnt_d < vstop) &&
             (hcnt_d > HSTART) && (hcnt_d < HSTOP);

    hx     = hcnt_d - HSTART - 10'd1;
    vy     = {1'b0, vcnt_d} - {1'b0, vstart} - 10'd1;
    cb_bit = ^((hx ^ vy) & (10'd1 << CB_SHIFT));

    ramp_full = hx >> RAMP_SHIFT;
    ramp_lvl  = (int'(ramp_full) > LVL_MAX) ? LVL_ONES : ramp_full[COLOR_W-1:0];

    // Fine checker phase: seeded from the line parity one pixel before the
    // window opens, so the first active pixel of an odd line is dark.
    phase_d = phase_q;
    if (hcnt_d == HSTART) begin
      phase_d = vcnt_d[0];
    end else if (win_d) begin
      phase_d = ~phase_q;
    end

    // Bar counters hold the bar position of the next window pixel and are
    // kept at zero outside the window so every line starts on bar 0.
    bar_cnt_d = '0;
    bar_idx_d = 3'd0;
    if (win_d) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? bar_idx_q : bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BCW'(1);
        bar_idx_d = bar_idx_q;
      end
    end

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (win_d) begin
      case (pat_d)
        2'd0: begin
          r_d = {COLOR_W{phase_d}};
          g_d = {COLOR_W{phase_d}};
          b_d = {COLOR_W{phase_d}};
        end
        2'd1: begin
          r_d = {COLOR_W{cb_bit}};
          g_d = {COLOR_W{cb_bit}};
          b_d = {COLOR_W{cb_bit}};
        end
        2'd2: begin
          r_d = {COLOR_W{~bar_idx_q[1]}};
          g_d = {COLOR_W{~bar_idx_q[2]}};
          b_d = {COLOR_W{~bar_idx_q[0]}};
        end
        default: begin
          r_d = ramp_lvl;
          g_d = ramp_lvl;
          b_d = ramp_lvl;
        end
      endcase
    end

    vdata_d = {Sync_in, r_d, g_d, b_d};
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pat_q     <= '0;
      phase_q   <= 1'b0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      vdata_q   <= '0;
      win_q     <= 1'b0;
    end else if (!nDSYNC) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pat_q     <= pat_d;
      phase_q   <= phase_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      vdata_q   <= vdata_d;
      win_q     <= win_d;
    end
  end

  assign vdata_out = vdata_q;
  assign in_window = win_q;

endmodule

// File: tb/tb_n64a_testpattern_gen.sv
// Testbench for n64a_testpattern_gen: randomized sync streams with random
// idle strobes, checked pixel by pixel against a behavioural model.
// The vertical windows are shortened so that complete frames fit the run.
module tb_n64a_testpattern_gen;

  localparam int COLOR_W  = 7;
  localparam int DW       = 3 * COLOR_W + 4;
  localparam int P_HSTART = 100;
  localparam int P_HSTOP  = 740;
  localparam int P_VS_N   = 2;
  localparam int P_VE_N   = 8;
  localparam int P_VS_P   = 3;
  localparam int P_VE_P   = 14;
  localparam int P_CB     = 3;
  localparam int P_BAR    = 80;
  localparam int P_RAMP   = 2;
  localparam int MAXV     = (1 << COLOR_W) - 1;

  logic          VCLK    = 1'b0;
  logic          nRST    = 1'b1;
  logic          nDSYNC  = 1'b1;
  logic          vmode   = 1'b0;
  logic [1:0]    pat_sel = 2'd0;
  logic [3:0]    Sync_in = 4'd0;
  logic [DW-1:0] vdata_out;
  logic          in_window;

  n64a_testpattern_gen #(
    .COLOR_W     (COLOR_W),
    .HSTART      (10'(P_HSTART)),
    .HSTOP       (10'(P_HSTOP)),
    .VSTART_NTSC (9'(P_VS_N)),
    .VSTOP_NTSC  (9'(P_VE_N)),
    .VSTART_PAL  (9'(P_VS_P)),
    .VSTOP_PAL   (9'(P_VE_P)),
    .CB_SHIFT    (P_CB),
    .BAR_W       (P_BAR),
    .RAMP_SHIFT  (P_RAMP)
  ) dut (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .nDSYNC    (nDSYNC),
    .vmode     (vmode),
    .pat_sel   (pat_sel),
    .Sync_in   (Sync_in),
    .vdata_out (vdata_out),
    .in_window (in_window)
  );

  always #5 VCLK = ~VCLK;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_h, m_v, m_pat;
  logic [3:0]    m_prev;
  logic [DW-1:0] m_exp;
  logic          m_win;
  logic [2:0]    bar_rgb [8];
  int            act_px;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h    = 0;
    m_v    = 0;
    m_pat  = 0;
    m_prev = 4'd0;
    m_exp  = '0;
    m_win  = 1'b0;
  endtask

  // Behavioural model of one strobe: position bookkeeping from the sync
  // rules, then the pattern value computed in closed form from the offsets.
  task automatic model_strobe(input logic [3:0] s);
    bit hs_r, vs_r, win;
    int vs0, ve0, hx, vy, r, g, b, idx, ph;
    logic [2:0] rgb;
    hs_r = !m_prev[1] && s[1];
    vs_r = !m_prev[3] && s[3];
    if (hs_r) m_h = 0;
    else if (m_h < 1023) m_h = m_h + 1;
    if (vs_r) m_v = 0;
    else if (hs_r && m_v < 511) m_v = m_v + 1;
    if (vs_r) m_pat = int'(pat_sel);
    m_prev = s;
    vs0 = vmode ? P_VS_P : P_VS_N;
    ve0 = vmode ? P_VE_P : P_VE_N;
    win = (m_v > vs0) && (m_v < ve0) && (m_h > P_HSTART) && (m_h < P_HSTOP);
    hx = m_h - P_HSTART - 1;
    vy = m_v - vs0 - 1;
    r = 0; g = 0; b = 0;
    if (win) begin
      case (m_pat)
        0: begin
          // Odd lines start dark, even lines start bright, then alternate.
          ph = (m_v % 2) ^ ((hx + 1) % 2);
          r = ph * MAXV; g = r; b = r;
        end
        1: begin
          ph = ((hx >> P_CB) ^ (vy >> P_CB)) & 1;
          r = ph * MAXV; g = r; b = r;
        end
        2: begin
          idx = hx / P_BAR;
          if (idx > 7) idx = 7;
          rgb = bar_rgb[idx];
          r = rgb[2] ? MAXV : 0;
          g = rgb[1] ? MAXV : 0;
          b = rgb[0] ? MAXV : 0;
        end
        default: begin
          r = hx >> P_RAMP;
          if (r > MAXV) r = MAXV;
          g = r; b = r;
        end
      endcase
    end
    m_exp = {s, COLOR_W'(r), COLOR_W'(g), COLOR_W'(b)};
    m_win = win;
  endtask

  task automatic step(input logic [3:0] s, input logic ds);
    Sync_in = s;
    nDSYNC  = ds;
    @(posedge VCLK);
    #1;
    if (!ds) begin
      model_strobe(s);
      if (in_window) act_px++;
    end
    check_eq("vdata", 32'(vdata_out), 32'(m_exp));
    check_eq("in_window", 32'(in_window), 32'(m_win));
  endtask

  // One pixel strobe with random nCLAMP/nCSYNC, sometimes preceded by an
  // idle cycle carrying junk sync bits that must be ignored.
  task automatic pix(input logic vs, input logic hs);
    if ($urandom_range(0, 7) == 0) step(4'($urandom), 1'b1);
    step({vs, 1'($urandom), hs, 1'($urandom)}, 1'b0);
  endtask

  task automatic mid_reset();
    nRST = 1'b0;
    #1;
    model_reset();
    check_eq("rst_vdata", 32'(vdata_out), 32'(m_exp));
    check_eq("rst_win", 32'(in_window), 32'(m_win));
    repeat (2) @(posedge VCLK);
    #1;
    check_eq("rst_hold", 32'(vdata_out), 32'(m_exp));
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 1'b0);
      check_eq("rst_sync", 32'(vdata_out[DW-1 -: 4]), 32'hF);
    end
  endtask

  task automatic run_frame(input int fr, input logic vm, input logic [1:0] pat,
                           input logic [1:0] next_pat, input int nlines,
                           input bit coincide, input int long_ln, input int rst_ln);
    for (int ln = 0; ln < nlines; ln++) begin
      int   hi_len, vs0, ve0, exp_px;
      logic vs;
      if (ln == 0) vmode = vm;
      if (ln == 1) pat_sel = pat;
      if (ln == 5) pat_sel = next_pat;
      hi_len = (ln == long_ln) ? 1100 : 745 + $urandom_range(0, 15);
      act_px = 0;
      for (int k = 0; k < 4; k++) pix(ln > 2, 1'b0);
      for (int k = 0; k < hi_len; k++) begin
        vs = (ln > 2) || (ln == 2 && (coincide || k >= 20));
        pix(vs, 1'b1);
        if (ln == rst_ln && k == 400) mid_reset();
      end
      if (ln >= 3 && ln != rst_ln) begin
        vs0 = vm ? P_VS_P : P_VS_N;
        ve0 = vm ? P_VE_P : P_VE_N;
        exp_px = (m_v > vs0 && m_v < ve0) ? (P_HSTOP - P_HSTART - 1) : 0;
        check_eq("act_px", 32'(act_px), 32'(exp_px));
      end
      $display("frame %0d line %0d vmode %0d pattern %0d vcnt %0d active_px %0d",
               fr, ln, vm, m_pat, m_v, act_px);
    end
  endtask

  initial begin
    bar_rgb = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    model_reset();
    #3 nRST = 1'b0;
    #1;
    check_eq("por_vdata", 32'(vdata_out), 32'(m_exp));
    check_eq("por_win", 32'(in_window), 32'(m_win));
    repeat (2) @(posedge VCLK);
    #1 nRST = 1'b1;

    // frame, vmode, pattern, pat_sel set mid-frame, lines, coincident
    // H/V edge, long line, mid-line reset line
    run_frame(0, 1'b0, 2'd0, 2'd1, 10, 1'b1, -1, -1);
    run_frame(1, 1'b1, 2'd1, 2'd2, 16, 1'b0, -1, -1);
    run_frame(2, 1'b1, 2'd2, 2'd3, 16, 1'b1, -1, 6);
    run_frame(3, 1'b0, 2'd3, 2'd0, 10, 1'b0, 5, -1);
    run_frame(4, 1'b1, 2'd0, 2'd3, 16, 1'b1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
